game_state_ctrl: RTL

- Parametrised successor to the top-level DDR game state generator.
- Synchronises and debounces the reset and combo buttons, synchronises the pause switch, and runs a four-state game FSM (RESET/PAUSE/GAME/OVER).
- Adds life-driven game-over, a timed combo-display hold and a state-change strobe.
- Feeds the display mux, arrow scroller and score logic.

---
 rtl/game_state_ctrl.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/game_state_ctrl.sv
// ---------------------------------------------------------------------------
// game_state_ctrl
//
// Top-level game state generator for the dance game. Raw buttons and the
// pause switch are synchronised into the clk domain. The two buttons are
// also debounced into one-cycle press pulses. A four-state FSM
// (RESET/PAUSE/GAME/OVER) drives the display mux, arrow scroller and score
// logic. The block also holds the combo display on for a fixed time and
// pulses a strobe on every state change.
//
// Optional feature (compile-time macro GAME_STATE_LIFE_OVER_EN):
//   defined   - GAME moves to OVER when life reaches zero.
//   undefined - life is ignored, OVER is unreachable, game_over is tied 0.
//
// Parameters:
//   STATE_BITS        MSB index of the state bus (bus is STATE_BITS+1 wide)
//   LIFE_W            width of the life input
//   SYNC_STAGES       flops per input synchroniser (>= 2)
//   DEBOUNCE_CYCLES   stable cycles before a button level is accepted (>= 1)
//   COMBO_HOLD_CYCLES combo display hold time; 0 selects level mode
//
// Ports:
//   clk              system clock
//   rst_n            asynchronous active-low reset
//   btn_reset        raw reset button, active-high, asynchronous
//   btn_combo        raw combo-display button, active-high, asynchronous
//   pause_sw         raw pause switch, 1 = paused
//   life             remaining lives from the score logic (unsigned)
//   output_state     RESET=0, PAUSE=1, GAME=2, OVER=3
//   display_combo_en high while the combo display is shown
//   game_over        high while in OVER
//   state_changed    one-cycle strobe on the first cycle of a new state
// ---------------------------------------------------------------------------
module game_state_ctrl #(
    parameter int STATE_BITS        = 1,
    parameter int LIFE_W            = 3,
    parameter int SYNC_STAGES       = 2,
    parameter int DEBOUNCE_CYCLES   = 250000,
    parameter int COMBO_HOLD_CYCLES = 50000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              btn_reset,
    input  logic              btn_combo,
    input  logic              pause_sw,
    input  logic [LIFE_W-1:0] life,
    output logic [STATE_BITS:0] output_state,
    output logic              display_combo_en,
    output logic              game_over,
    output logic              state_changed
);

    localparam int SW = STATE_BITS + 1;
    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    typedef enum logic [STATE_BITS:0] {
        S_RESET = SW'(0),
        S_PAUSE = SW'(1),
        S_GAME  = SW'(2),
        S_OVER  = SW'(3)
    } state_t;

    // Raw input order inside the synchroniser bank.
    localparam int I_RESET = 0;
    localparam int I_COMBO = 1;
    localparam int I_PAUSE = 2;

    // -----------------------------------------------------------------------
    // Input synchronisers
    // -----------------------------------------------------------------------
    logic [2:0]                  raw_in;
    logic [2:0][SYNC_STAGES-1:0] sync_q;
    logic [2:0]                  sync_out;

    assign raw_in = {pause_sw, btn_combo, btn_reset};

    // NOTE: sequential state uses non-blocking assignments and an async
    // reset in the sensitivity list, so every flop clears the moment rst_n
    // falls, without waiting for a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], raw_in[i]};
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            sync_out[i] = sync_q[i][SYNC_STAGES-1];
        end
    end

    logic pause_s;
    assign pause_s = sync_out[I_PAUSE];

    // -----------------------------------------------------------------------
    // Button debounce: index 0 = reset button, index 1 = combo button.
    // The accepted level only flips after DEBOUNCE_CYCLES consecutive cycles
    // that disagree with it. Only a 0->1 flip produces a press pulse.
    // -----------------------------------------------------------------------
    logic [1:0]           btn_s;
    logic [1:0][DB_W-1:0] db_cnt;
    logic [1:0]           db_level;
    logic [1:0]           db_press;

    assign btn_s = {sync_out[I_COMBO], sync_out[I_RESET]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt   <= '0;
            db_level <= '0;
            db_press <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                db_press[i] <= 1'b0;
                if (btn_s[i] == db_level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    db_level[i] <= btn_s[i];
                    db_press[i] <= btn_s[i];
                    db_cnt[i]   <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    logic reset_press;
    logic combo_press;
    logic combo_level;

    assign reset_press = db_press[0];
    assign combo_press = db_press[1];
    assign combo_level = db_level[1];

    // -----------------------------------------------------------------------
    // Game FSM
    // -----------------------------------------------------------------------
    state_t state;
    state_t next_state;
    logic   lives_out;
    logic   game_over_q;
    logic   state_changed_q;

`ifdef GAME_STATE_LIFE_OVER_EN
    assign lives_out = (state == S_GAME) && (life == '0);
    assign game_over = game_over_q;
`else
    // Life has no effect in this build; OVER can never be entered.
    logic unused_life_over;
    assign unused_life_over = ^{life, game_over_q};
    assign lives_out        = 1'b0;
    assign game_over        = 1'b0;
`endif

    // NOTE: next_state gets a default before the case so that every path
    // assigns it and no latch is inferred.
    always_comb begin
        next_state = state;
        case (state)
            S_RESET: next_state = pause_s ? S_PAUSE : S_GAME;
            S_GAME: begin
                if (lives_out) begin
                    next_state = S_OVER;
                end else if (pause_s) begin
                    next_state = S_PAUSE;
                end
            end
            S_PAUSE: begin
                if (reset_press) begin
                    next_state = S_RESET;
                end else if (!pause_s) begin
                    next_state = S_GAME;
                end
            end
            S_OVER: begin
                if (reset_press) begin
                    next_state = S_RESET;
                end
            end
            default: next_state = S_RESET;
        endcase
    end

    // Outputs are registered from next_state so they line up with the state
    // register itself rather than lagging it by a cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= S_RESET;
            game_over_q     <= 1'b0;
            state_changed_q <= 1'b0;
        end else begin
            state           <= next_state;
            game_over_q     <= (next_state == S_OVER);
            state_changed_q <= (next_state != state);
        end
    end

    assign output_state  = state;
    assign state_changed = state_changed_q;

    // -----------------------------------------------------------------------
    // Combo display
    // -----------------------------------------------------------------------
    logic show_ok;
    logic combo_clear;
    logic combo_en_q;

    // The combo screen is only meaningful while the game is not running.
    assign show_ok     = (state == S_PAUSE) || (state == S_OVER);
    assign combo_clear = (next_state == S_GAME) || (next_state == S_RESET);

    if (COMBO_HOLD_CYCLES > 0) begin : g_hold
        localparam int HOLD_W = $clog2(COMBO_HOLD_CYCLES + 1);
        logic [HOLD_W-1:0] hold_cnt;

        // Counter holds the number of display cycles still to show; the
        // enable drops on the edge that takes it from 1 to 0.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                hold_cnt   <= '0;
                combo_en_q <= 1'b0;
            end else if (combo_clear) begin
                hold_cnt   <= '0;
                combo_en_q <= 1'b0;
            end else if (combo_press && show_ok) begin
                hold_cnt   <= HOLD_W'(COMBO_HOLD_CYCLES);
                combo_en_q <= 1'b1;
            end else if (hold_cnt != '0) begin
                hold_cnt   <= hold_cnt - 1'b1;
                combo_en_q <= (hold_cnt != HOLD_W'(1));
            end
        end
    end else begin : g_level
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                combo_en_q <= 1'b0;
            end else begin
                combo_en_q <= combo_level && show_ok;
            end
        end
    end

    assign display_combo_en = combo_en_q;

endmodule
